l2_cacheline_adapter: RTL
=========================

# l2_cacheline_adapter

Downstream neighbour of the L2 cache. It converts the L2's single-transfer 256-bit line requests into four-beat 64-bit bursts on the physical memory bus, and assembles returning beats back into one line. It connects the L2 `pmem_*` port to main memory. One request is in flight at a time.

## Interface
- `BEATS`, default 4: beats per line; fixed so that `BEATS*64 = 256`.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `pmem_read  in  1`: line read request from the L2; held high until `pmem_resp`.
- `pmem_write  in  1`: line write request from the L2; held high until `pmem_resp`.
- `pmem_address  in  32`: line address.
- `pmem_wdata  in  256`: line to write.
- `pmem_resp  out  1`: one-cycle completion pulse to the L2.
- `pmem_rdata  out  256`: assembled read line.
- `mem_read  out  1`: burst read request to memory.
- `mem_write  out  1`: burst write request to memory.
- `mem_address  out  32`: burst address, held for the whole burst.
- `mem_wdata  out  64`: current write beat.
- `mem_rdata  in  64`: current read beat.
- `mem_resp  in  1`: memory accepted or delivered the current beat.

## Operation
- States: `IDLE`, `RD`, `WR`, `DONE`. A 2-bit beat counter `cnt` is cleared whenever the FSM is in `IDLE`.
- **IDLE:**
  - `pmem_write` set: latch the address into `addr_q` and `pmem_wdata` into `wbuf`, then go to `WR`.
  - Otherwise, `pmem_read` set: latch the address, then go to `RD`.
  - Both set: write wins.
- **RD:**
  - `mem_read=1`.
  - On `mem_resp`, write `mem_rdata` into `rbuf[64*cnt +: 64]` and increment `cnt`.
  - On the beat with `cnt==3`, go to `DONE`.
- **WR:**
  - `mem_write=1` and `mem_wdata = wbuf[64*cnt +: 64]`.
  - On `mem_resp`, increment `cnt`.
  - On the beat with `cnt==3`, go to `DONE`.
- **DONE:** `pmem_resp=1` for exactly one cycle, then go to `IDLE`.
  - Because the L2 drops its request on the edge after `pmem_resp`, no duplicate request is issued.
- `mem_address = addr_q` during `RD` and `WR`, and 0 otherwise.
- `pmem_rdata = rbuf`. It holds its value from `DONE` until the next read overwrites beat 0. Write transactions do not alter it.
- `mem_resp` outside `RD`/`WR` is ignored.
- `mem_rdata` is ignored except on beats accepted in `RD`.
- Changes to `pmem_*` inputs after IDLE latching are ignored until the FSM returns to `IDLE`.
- `cnt` wraps 3→0 on the last beat. It is therefore 0 in `DONE`.

## Timing
- Reset values:
  - state `IDLE`, `cnt=0`, `rbuf=0`, `wbuf=0`, `addr_q=0`.
  - Outputs: `pmem_resp=0`, `pmem_rdata=0`, `mem_read=0`, `mem_write=0`, `mem_address=0`, `mem_wdata=0`.
- Request sampled at edge E0. `mem_read` or `mem_write` is high from E0 onward, i.e. one cycle after the request is visible.
- Memory returning beats on consecutive cycles starting right after E0:
  - beats are captured at edges E1 through E4;
  - `pmem_resp` is high in the cycle E4–E5;
  - back in `IDLE` at E5.
- Minimum request-to-response latency: 5 cycles.
- Wait states: `mem_resp` may be low for any number of cycles between beats. All outputs hold steady while waiting.
- Next request can be sampled at E6 at the earliest, one idle cycle after `DONE`.
- Reset asserted mid-burst:
  - `mem_read`/`mem_write` drop immediately (asynchronously);
  - all registers clear;
  - no `pmem_resp` is generated.

## Configuration
- `L2_ADAPTER_ALIGN_EN`:
  - Defined: `addr_q` latches `{pmem_address[31:5], 5'b0}`, so memory always sees line-aligned addresses.
  - Undefined: `addr_q` latches `pmem_address` unchanged. Callers must supply aligned addresses.

## Test plan
- Reset mid-read: issue a read, assert `rst` after beat 1 → `mem_read` is 0 in the same cycle, no `pmem_resp`, `pmem_rdata=0`; a following read completes normally.
- Read at 0x0000_1040, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → `mem_address=0x0000_1040` for 4 cycles; `pmem_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}`; `pmem_resp` pulses once, 5 cycles after the request.
- Write of line `{64'hD, 64'hC, 64'hB, 64'hA}` with 2 wait cycles before each beat → `mem_wdata` steps A, B, C, D, each stable until its `mem_resp`; one `pmem_resp`; `pmem_rdata` unchanged.
- Read and write asserted together at 0x80 → write burst occurs; `mem_read` never asserts.
- Stray `mem_resp` pulses in `IDLE`, then a normal read → `cnt` unaffected; the line assembles correctly.
- With `L2_ADAPTER_ALIGN_EN`, request address 0x0000_105C → `mem_address=0x0000_1040`. Without it → `mem_address=0x0000_105C`.

Source files
------------

// File: rtl/l2_cacheline_adapter.sv
// Converts single-transfer 256-bit L2 line requests into 64-bit memory bursts and assembles read beats into a line.
// Optional macro L2_ADAPTER_ALIGN_EN forces the latched burst address to a 32-byte line boundary.
module l2_cacheline_adapter #(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_cnt;
  logic [31:0]  r_addr_q;
  logic [255:0] r_rbuf;
  logic [255:0] r_wbuf;

  logic         w_in_burst;
  logic         w_beat_ok;
  logic         w_last_beat;
  logic [31:0]  w_addr_latch;
  logic [7:0]   w_beat_base;

`ifdef L2_ADAPTER_ALIGN_EN
  assign w_addr_latch = pmem_address & 32'hFFFF_FFE0;
`else
  assign w_addr_latch = pmem_address;
`endif

  assign w_in_burst  = (r_state == RD) || (r_state == WR);
  assign w_beat_ok   = w_in_burst && mem_resp;
  assign w_last_beat = w_beat_ok && (r_cnt == LAST_BEAT);
  assign w_beat_base = {r_cnt, 6'b0};

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (pmem_write)     w_state_nxt = WR;
        else if (pmem_read) w_state_nxt = RD;
      end
      RD, WR: begin
        if (w_last_beat) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 2'd0;
    end else if (r_state == IDLE) begin
      r_cnt <= 2'd0;
    end else if (w_beat_ok) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Request fields are captured only in IDLE; later changes on pmem_* are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q <= 32'd0;
      r_wbuf   <= '0;
    end else if (r_state == IDLE) begin
      if (pmem_write) begin
        r_addr_q <= w_addr_latch;
        r_wbuf   <= pmem_wdata;
      end else if (pmem_read) begin
        r_addr_q <= w_addr_latch;
      end
    end
  end

  // NOTE: the line buffers are reset because pmem_rdata must read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbuf <= '0;
    end else if ((r_state == RD) && mem_resp) begin
      r_rbuf[w_beat_base +: 64] <= mem_rdata;
    end
  end

  // Outputs decode the state register directly, so reset drops the burst strobes asynchronously.
  always_comb begin
    pmem_resp   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 32'd0;
    mem_wdata   = 64'd0;
    unique case (r_state)
      RD: begin
        mem_read    = 1'b1;
        mem_address = r_addr_q;
      end
      WR: begin
        mem_write   = 1'b1;
        mem_address = r_addr_q;
        mem_wdata   = r_wbuf[w_beat_base +: 64];
      end
      DONE:    pmem_resp = 1'b1;
      default: ;
    endcase
  end

  assign pmem_rdata = r_rbuf;

endmodule
